// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and RAM signals shared between the arbiter and its environment
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ready;
  logic [DATA_W-1:0] i_rdata;
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  modport slave (
    input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, ram_addr, ram_wdata, ram_ren, ram_wen, busy
  );
  modport master (
    output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, ram_addr, ram_wdata, ram_ren, ram_wen, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and load/store
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input logic          clk,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] LAST = 4'(LATENCY - 1);
  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pend_d, pend_i, take_d, acc;
  assign pend_d = bus.d_ren | bus.d_wen;
  assign pend_i = bus.i_req;
  // data wins a tie only if the previous grant went to fetch
  assign take_d = pend_d & (~pend_i | ~last_d_q);
  assign acc    = state_q == ACCESS;
  // next-state: arbitrate in IDLE, count RAM latency in ACCESS, one-cycle RESP
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    last_d_d   = last_d_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      IDLE: if (pend_d | pend_i) begin
        state_d    = ACCESS;
        grant_d    = take_d;
        is_write_d = take_d & bus.d_wen;
        addr_d     = take_d ? bus.d_addr : bus.i_addr;
        wdata_d    = bus.d_wdata;
        cnt_d      = '0;
        last_d_d   = take_d;
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          state_d   = RESP;
          cnt_d     = '0;
          i_rdata_d = (!is_write_q && !grant_q) ? bus.ram_rdata : i_rdata_q;
          d_rdata_d = (!is_write_q && grant_q) ? bus.ram_rdata : d_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      last_d_q   <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      last_d_q   <= last_d_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
  assign bus.ram_addr  = acc ? addr_q : '0;
  assign bus.ram_wdata = (acc && is_write_q) ? wdata_q : '0;
  assign bus.ram_ren   = acc & ~is_write_q;
  assign bus.ram_wen   = acc & is_write_q;
  assign bus.i_ready   = (state_q == RESP) & ~grant_q;
  assign bus.d_ready   = (state_q == RESP) & grant_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected ready responses
module tb_mem_arbiter;
  localparam int LAT = 2;
  typedef struct {
    bit          d;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic nRST = 1'b0;
  int   total = 0;
  int   fails = 0;
  exp_t sb[$];
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT)) dut (.clk(clk), .nRST(nRST), .bus(bus));
  assign bus.ram_rdata = {bus.ram_addr[15:0], 16'hBEEF};
  always #5 clk = ~clk;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  // monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.i_ready || bus.d_ready) begin
      chk("mon one_ready", 32'(bus.i_ready & bus.d_ready), 32'd0);
      if (sb.size() == 0) begin
        chk("mon unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon port", 32'(bus.d_ready), 32'(e.d));
        chk("mon rdata", e.d ? bus.d_rdata : bus.i_rdata, e.data);
      end
    end
  end
  task automatic run_acc(input string nm, input bit d, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input bit drop);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      chk({nm, " ram_ren"}, 32'(bus.ram_ren), 32'(!w));
      chk({nm, " ram_wen"}, 32'(bus.ram_wen), 32'(w));
      chk({nm, " ram_addr"}, bus.ram_addr, a);
      chk({nm, " ram_wdata"}, bus.ram_wdata, w ? wd : 32'd0);
      chk({nm, " busy"}, 32'(bus.busy), 32'd1);
      if (drop && c == 0) begin
        bus.i_req = 1'b0;
        bus.d_ren = 1'b0;
        bus.d_wen = 1'b0;
      end
    end
    @(negedge clk);
    chk({nm, " i_ready"}, 32'(bus.i_ready), 32'(!d));
    chk({nm, " d_ready"}, 32'(bus.d_ready), 32'(d));
  endtask
  task automatic idle_chk(input string nm);
    @(negedge clk);
    chk({nm, " idle busy"}, 32'(bus.busy), 32'd0);
    chk({nm, " idle ready"}, 32'(bus.i_ready | bus.d_ready), 32'd0);
  endtask
  task automatic zero_chk(input string nm);
    chk({nm, " busy"}, 32'(bus.busy), 32'd0);
    chk({nm, " readys"}, 32'(bus.i_ready | bus.d_ready), 32'd0);
    chk({nm, " strobes"}, 32'(bus.ram_ren | bus.ram_wen), 32'd0);
    chk({nm, " ram_addr"}, bus.ram_addr, 32'd0);
    chk({nm, " ram_wdata"}, bus.ram_wdata, 32'd0);
    chk({nm, " i_rdata"}, bus.i_rdata, 32'd0);
    chk({nm, " d_rdata"}, bus.d_rdata, 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_req = 0; bus.i_addr = 0; bus.d_ren = 0; bus.d_wen = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) @(negedge clk);
    zero_chk("reset");
    nRST = 1'b1;
    @(negedge clk);
    sb.push_back('{0, 32'h0010BEEF});
    bus.i_req = 1; bus.i_addr = 32'h10;
    run_acc("t1", 0, 0, 32'h10, 0, 0);
    bus.i_req = 0;
    idle_chk("t1");
    sb.push_back('{1, 32'h0});
    bus.d_wen = 1; bus.d_addr = 32'h24; bus.d_wdata = 32'hCAFEF00D;
    run_acc("t2", 1, 1, 32'h24, 32'hCAFEF00D, 0);
    bus.d_wen = 0;
    idle_chk("t2");
    chk("t2 d_rdata", bus.d_rdata, 32'h0);
    nRST = 1'b0;
    @(negedge clk);
    bus.i_req = 1; bus.i_addr = 32'h40; bus.d_ren = 1; bus.d_addr = 32'h80;
    nRST = 1'b1;
    sb.push_back('{1, 32'h0080BEEF});
    sb.push_back('{0, 32'h0040BEEF});
    sb.push_back('{1, 32'h0080BEEF});
    run_acc("t3 d1", 1, 0, 32'h80, 0, 0);
    idle_chk("t3 a");
    run_acc("t3 i", 0, 0, 32'h40, 0, 0);
    chk("t3 d_rdata held", bus.d_rdata, 32'h0080BEEF);
    idle_chk("t3 b");
    run_acc("t3 d2", 1, 0, 32'h80, 0, 0);
    bus.i_req = 0; bus.d_ren = 0;
    idle_chk("t3 c");
    chk("t3 i_rdata", bus.i_rdata, 32'h0040BEEF);
    sb.push_back('{1, 32'h0080BEEF});
    bus.d_ren = 1; bus.d_wen = 1; bus.d_addr = 32'h30; bus.d_wdata = 32'h12345678;
    run_acc("t4", 1, 1, 32'h30, 32'h12345678, 0);
    bus.d_ren = 0; bus.d_wen = 0;
    idle_chk("t4");
    sb.push_back('{0, 32'h0050BEEF});
    bus.i_req = 1; bus.i_addr = 32'h50;
    run_acc("t5", 0, 0, 32'h50, 0, 1);
    idle_chk("t5 a");
    idle_chk("t5 b");
    bus.i_req = 1; bus.i_addr = 32'h60;
    @(negedge clk);
    chk("t6 busy before reset", 32'(bus.busy), 32'd1);
    nRST = 1'b0;
    #1;
    zero_chk("t6 async");
    bus.i_req = 0;
    @(negedge clk);
    nRST = 1'b1;
    idle_chk("t6 a");
    idle_chk("t6 b");
    idle_chk("t6 c");
    sb.push_back('{1, 32'h0070BEEF});
    bus.d_ren = 1; bus.d_addr = 32'h70;
    run_acc("t6 new", 1, 0, 32'h70, 0, 0);
    bus.d_ren = 0;
    idle_chk("t6 d");
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer that shares the single-ported instruction/data RAM between the instruction-fetch path (PC side) and the load/store path (ALU/register side) of the RISC-V core. It accepts one fetch requester and one data requester, grants the RAM to one of them at a time, holds address and strobes stable for a fixed RAM latency, and returns read data with a one-cycle ready pulse. Its `i_ready` drives the PC enable and its `d_ready` replaces the constant-zero data ready in the core top level.

## Interface
- `ADDR_W`, default 32: address width, both requesters and RAM.
- `DATA_W`, default 32: data width.
- `LATENCY`, default 2: number of cycles the RAM needs with address/strobe held before `ram_rdata` is valid. Legal values are 1 to 15.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `i_req` in 1: instruction fetch request.
- `i_addr` in ADDR_W: fetch address (PC).
- `i_ready` out 1: one-cycle pulse; `i_rdata` is valid.
- `i_rdata` out DATA_W: fetched instruction, registered.
- `d_ren` in 1: data load request.
- `d_wen` in 1: data store request.
- `d_addr` in ADDR_W: data address (ALU result).
- `d_wdata` in DATA_W: store data.
- `d_ready` out 1: one-cycle pulse; the load or store is complete.
- `d_rdata` out DATA_W: load data, registered.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_ren` out 1: RAM read strobe.
- `ram_wen` out 1: RAM write strobe.
- `ram_rdata` in DATA_W: RAM read data.
- `busy` out 1: high whenever an access is in flight (ACCESS or RESP).

## Operation
States: IDLE, ACCESS, RESP.

Registers:
- `grant`: I or D.
- `is_write`.
- `addr_q`, `wdata_q`.
- `cnt`: 4 bits.
- `last_d`: last grant went to data.
- `i_rdata`, `d_rdata`.

IDLE:
- Sample the requests; a request is "data" if `d_ren|d_wen`, "fetch" if `i_req`.
- Only one kind pending: grant it.
- Both pending: grant D if `last_d`=0, else grant I. This gives data priority with no back-to-back starvation of fetch.
- On grant:
  - latch `addr_q` and `wdata_q`;
  - latch `is_write` = `d_wen` (D grant only; `d_wen` wins if both `d_ren` and `d_wen` are high);
  - set `cnt`=0, go to ACCESS;
  - update `last_d` (1 for a D grant, 0 for an I grant).
- Nothing pending: stay in IDLE.

ACCESS:
- `ram_addr`=`addr_q`.
- `ram_ren`=!`is_write`, `ram_wen`=`is_write`.
- `ram_wdata`=`wdata_q` when writing, 0 otherwise.
- `cnt` increments each cycle.
- When `cnt`==LATENCY-1:
  - if the access is a read, capture `ram_rdata` into `i_rdata` (grant I) or `d_rdata` (grant D);
  - go to RESP.
- `d_rdata` is unchanged on a store.

RESP:
- Pulse `i_ready` (grant I) or `d_ready` (grant D) for exactly one cycle.
- Go to IDLE.

Requesters hold address and request until they see ready. After a grant, input changes are ignored. A request dropped mid-access still completes and still produces its ready pulse. Outside ACCESS, `ram_addr`, `ram_wdata`, `ram_ren` and `ram_wen` are all 0.

## Timing
- Reset (`nRST`=0, asynchronous): the following take effect immediately, including mid-access:
  - state=IDLE, `cnt`=0, `last_d`=0;
  - `i_rdata`=`d_rdata`=0;
  - `i_ready`=`d_ready`=0, `busy`=0;
  - RAM strobes, `ram_addr` and `ram_wdata` all 0.
  - An interrupted access produces no ready pulse.
- Latency: request sampled in IDLE at edge 0. ACCESS occupies cycles 1..LATENCY. Ready is high during cycle LATENCY+1 with registered data. The earliest next grant is sampled in the cycle after RESP.
- Throughput: one access per LATENCY+2 cycles.
- `busy` is high during ACCESS and RESP.
- Ready outputs and read-data registers are Moore (registered/state-decoded); there is no combinational path from inputs to outputs.
- `cnt` never exceeds LATENCY-1. With LATENCY=1, ACCESS lasts exactly one cycle.
- Read data registers hold their value until the next read for the same port.

## Test plan
(All with LATENCY=2, RAM model returning `{addr[15:0], 16'hBEEF}` for any address.)
1. Reset, then `i_req`=1, `i_addr`=0x10 held → `ram_ren`=1 with `ram_addr`=0x10 for 2 cycles; `i_ready` pulses in cycle 3 with `i_rdata`=0x0010BEEF; `d_ready` stays 0.
2. `d_wen`=1, `d_addr`=0x24, `d_wdata`=0xCAFEF00D → `ram_wen`=1 with `ram_wdata`=0xCAFEF00D for 2 cycles; `d_ready` pulses once; `d_rdata` stays 0.
3. `i_req` and `d_ren` asserted together and held from reset → D granted first (`d_rdata`=D-address data), then I granted (`last_d`=1) even though `d_ren` is still high; then D again.
4. `d_ren` and `d_wen` both 1 → the access is a write (`ram_wen`=1, `ram_ren`=0).
5. Drop `i_req` in the first ACCESS cycle → the access completes and `i_ready` still pulses once; the arbiter then idles with `busy`=0.
6. Assert `nRST`=0 in the middle of ACCESS → all outputs 0 immediately; after release, no stale ready pulse; a new request completes normally.
